processing_unit: RTL and testbench

- Datapath that sits directly downstream of Control_Unit and consumes all of its control strobes and mux selects.
- Holds the register file R0-R3, PC, IR, the address register Add_R and the zero flag Reg_Z.
- Contains the 8-bit ALU and the Bus_1a, Bus_1b and Bus_2 multiplexers, and drives the unified memory port.
- Returns `instruction` and `zero` to Control_Unit, closing the fetch/decode/execute loop.

---
 rtl/processing_defs.sv | 71 +++++++
 rtl/processing_unit_if.sv | 59 +++++
 rtl/processing_alu.sv | 34 +++
 rtl/processing_unit.sv | 99 +++++++++
 tb/tb_processing_unit.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/processing_defs.sv
`default_nettype none
// ============================================================================
//  Package     : processing_defs
//  Description : Shared widths, bus select codes and ALU opcodes for the
//                processing unit datapath and its control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package processing_defs;

  localparam int WORD_SIZE    = 10;
  localparam int DATA_SIZE    = 8;
  localparam int ADDRESS_SIZE = 8;
  localparam int OP_SIZE      = 4;
  localparam int SEL1_SIZE    = 3;
  localparam int SEL2_SIZE    = 3;

  // Bus_1a / Bus_1b source codes; 6 and 7 drive zero
  typedef enum logic [SEL1_SIZE-1:0] {
    SEL1_R0    = 3'd0,
    SEL1_R1    = 3'd1,
    SEL1_R2    = 3'd2,
    SEL1_R3    = 3'd3,
    SEL1_PC    = 3'd4,
    SEL1_CONST = 3'd5
  } sel1_e;

  // Bus_2 source codes; 5 to 7 drive zero
  typedef enum logic [SEL2_SIZE-1:0] {
    SEL2_ALU    = 3'd0,
    SEL2_BUS_1A = 3'd1,
    SEL2_MEM    = 3'd2,
    SEL2_CONST  = 3'd3,
    SEL2_ADDR   = 3'd4
  } sel2_e;

  // ALU opcodes carried in IR[9:6]; any other code passes operand a
  typedef enum logic [OP_SIZE-1:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    NOT = 4'd4
  } alu_op_e;

  // Shared Bus_1 multiplexer used for both the a and b operand buses
  function automatic logic [DATA_SIZE-1:0] bus_1_mux(
    input logic [SEL1_SIZE-1:0] sel,
    input logic [DATA_SIZE-1:0] r0,
    input logic [DATA_SIZE-1:0] r1,
    input logic [DATA_SIZE-1:0] r2,
    input logic [DATA_SIZE-1:0] r3,
    input logic [DATA_SIZE-1:0] pc,
    input logic [DATA_SIZE-1:0] cst
  );
    logic [DATA_SIZE-1:0] v;
    v = '0;
    case (sel)
      SEL1_R0:    v = r0;
      SEL1_R1:    v = r1;
      SEL1_R2:    v = r2;
      SEL1_R3:    v = r3;
      SEL1_PC:    v = pc;
      SEL1_CONST: v = cst;
      default:    v = '0;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/processing_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface   : processing_unit_if
//  Description : Control strobes, mux selects and unified memory port that
//                connect the control unit, the datapath and memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface processing_unit_if;
  import processing_defs::*;

  logic                    Load_R0;
  logic                    Load_R1;
  logic                    Load_R2;
  logic                    Load_R3;
  logic                    Load_PC;
  logic                    Inc_PC;
  logic [SEL1_SIZE-1:0]    Sel_Bus_1a_Mux;
  logic [SEL1_SIZE-1:0]    Sel_Bus_1b_Mux;
  logic [SEL2_SIZE-1:0]    Sel_Bus_2_Mux;
  logic                    Load_IR;
  logic                    Load_Add_R;
  logic                    Load_Reg_Z;
  logic [ADDRESS_SIZE-1:0] address_decoded;
  logic [DATA_SIZE-1:0]    constant_decoded;
  logic [WORD_SIZE-1:0]    instruction;
  logic                    zero;
  logic [WORD_SIZE-1:0]    mem_rdata;
  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0]    mem_wdata;

  // Control unit side
  modport master (
    output Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
    output Sel_Bus_1a_Mux, Sel_Bus_1b_Mux, Sel_Bus_2_Mux,
    output Load_IR, Load_Add_R, Load_Reg_Z,
    output address_decoded, constant_decoded,
    input  instruction, zero
  );

  // Datapath side
  modport slave (
    input  Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
    input  Sel_Bus_1a_Mux, Sel_Bus_1b_Mux, Sel_Bus_2_Mux,
    input  Load_IR, Load_Add_R, Load_Reg_Z,
    input  address_decoded, constant_decoded,
    output instruction, zero,
    input  mem_rdata,
    output mem_addr, mem_wdata
  );

  // Memory side
  modport mem (
    input  mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/processing_alu.sv
`default_nettype none
// ============================================================================
//  Module      : processing_alu
//  Description : Combinational 8-bit ALU; no carry or overflow is kept.
//  Revision    : 1.0 - initial release
// ============================================================================
module processing_alu
  import processing_defs::*;
(
  input  logic [DATA_SIZE-1:0] a,
  input  logic [DATA_SIZE-1:0] b,
  input  logic [OP_SIZE-1:0]   op,
  output logic [DATA_SIZE-1:0] result,
  output logic                 zero
);

  // Operation select; unknown opcodes pass operand a
  always_comb begin
    result = a;
    case (op)
      ADD:     result = a + b;
      SUB:     result = a - b;
      AND:     result = a & b;
      OR:      result = a | b;
      NOT:     result = ~a;
      default: result = a;
    endcase
  end

  assign zero = (result == '0);

endmodule

`default_nettype wire

// File: rtl/processing_unit.sv
`default_nettype none
// ============================================================================
//  Module      : processing_unit
//  Description : Datapath holding R0-R3, PC, IR, Add_R and Reg_Z, the ALU and
//                the Bus_1a/Bus_1b/Bus_2 multiplexers; drives the memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
module processing_unit
  import processing_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  processing_unit_if.slave  bus
);

  logic [DATA_SIZE-1:0]    r_reg [4];
  logic [ADDRESS_SIZE-1:0] r_pc;
  logic [WORD_SIZE-1:0]    r_ir;
  logic [ADDRESS_SIZE-1:0] r_add_r;
  logic                    r_reg_z;

  logic [DATA_SIZE-1:0]    w_bus_1a;
  logic [DATA_SIZE-1:0]    w_bus_1b;
  logic [DATA_SIZE-1:0]    w_bus_2;
  logic [DATA_SIZE-1:0]    w_alu_out;
  logic                    w_alu_zero;
  logic [3:0]              w_load_r;

  assign w_load_r = {bus.Load_R3, bus.Load_R2, bus.Load_R1, bus.Load_R0};

  assign w_bus_1a = bus_1_mux(bus.Sel_Bus_1a_Mux, r_reg[0], r_reg[1], r_reg[2],
                              r_reg[3], r_pc, bus.constant_decoded);
  assign w_bus_1b = bus_1_mux(bus.Sel_Bus_1b_Mux, r_reg[0], r_reg[1], r_reg[2],
                              r_reg[3], r_pc, bus.constant_decoded);

  processing_alu u_alu (
    .a      (w_bus_1a),
    .b      (w_bus_1b),
    .op     (r_ir[WORD_SIZE-1 -: OP_SIZE]),
    .result (w_alu_out),
    .zero   (w_alu_zero)
  );

  // Bus_2 source select; only the low data byte of a memory word is routed
  always_comb begin
    w_bus_2 = '0;
    case (bus.Sel_Bus_2_Mux)
      SEL2_ALU:    w_bus_2 = w_alu_out;
      SEL2_BUS_1A: w_bus_2 = w_bus_1a;
      SEL2_MEM:    w_bus_2 = bus.mem_rdata[DATA_SIZE-1:0];
      SEL2_CONST:  w_bus_2 = bus.constant_decoded;
      SEL2_ADDR:   w_bus_2 = bus.address_decoded;
      default:     w_bus_2 = '0;
    endcase
  end

  // Register file: every strobed register takes the same Bus_2 value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_load_r[i]) r_reg[i] <= w_bus_2;
      end
    end
  end

  // Program counter: a load overrides an increment; increment wraps at 8'hFF
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= '0;
    end else if (bus.Load_PC) begin
      r_pc <= w_bus_2;
    end else if (bus.Inc_PC) begin
      r_pc <= r_pc + 8'd1;
    end
  end

  // Instruction, address and zero-flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir    <= '0;
      r_add_r <= '0;
      r_reg_z <= 1'b0;
    end else begin
      if (bus.Load_IR)    r_ir    <= bus.mem_rdata;
      if (bus.Load_Add_R) r_add_r <= w_bus_2;
      if (bus.Load_Reg_Z) r_reg_z <= w_alu_zero;
    end
  end

  assign bus.instruction = r_ir;
  assign bus.zero        = r_reg_z;
  assign bus.mem_addr    = r_add_r;
  assign bus.mem_wdata   = w_bus_1a;

endmodule

`default_nettype wire

// File: tb/tb_processing_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_processing_unit
//  Description : Self-checking bench for processing_unit: directed vector
//                table, reset sequences and randomized model comparison.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_processing_unit;

  // Strobe bit positions packed as {Z, AR, IR, INC, PC, R3, R2, R1, R0}
  localparam logic [8:0] S_R0  = 9'h001;
  localparam logic [8:0] S_R1  = 9'h002;
  localparam logic [8:0] S_R2  = 9'h004;
  localparam logic [8:0] S_R3  = 9'h008;
  localparam logic [8:0] S_PC  = 9'h010;
  localparam logic [8:0] S_INC = 9'h020;
  localparam logic [8:0] S_IR  = 9'h040;
  localparam logic [8:0] S_AR  = 9'h080;
  localparam logic [8:0] S_Z   = 9'h100;

  typedef struct {
    string      name;
    logic [8:0] stb;
    logic [2:0] s1a, s1b, s2;
    logic [7:0] adr, cst;
    logic [2:0] obs;
    logic [9:0] e_ins;
    logic       e_z;
    logic [7:0] e_ma;
    logic [7:0] e_wd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] mem [256];
  int         n_checks = 0;
  int         n_errors = 0;

  // Reference model state
  logic [7:0] m_r [4];
  logic [7:0] m_pc, m_ar;
  logic [9:0] m_ir;
  logic       m_z;

  processing_unit_if bus ();

  processing_unit dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr];

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [8:0] stb, input logic [2:0] s1a, input logic [2:0] s1b,
                       input logic [2:0] s2, input logic [7:0] adr, input logic [7:0] cst);
    bus.Load_R0 = stb[0];  bus.Load_R1 = stb[1];  bus.Load_R2 = stb[2];
    bus.Load_R3 = stb[3];  bus.Load_PC = stb[4];  bus.Inc_PC  = stb[5];
    bus.Load_IR = stb[6];  bus.Load_Add_R = stb[7]; bus.Load_Reg_Z = stb[8];
    bus.Sel_Bus_1a_Mux = s1a; bus.Sel_Bus_1b_Mux = s1b; bus.Sel_Bus_2_Mux = s2;
    bus.address_decoded = adr; bus.constant_decoded = cst;
  endtask

  function automatic vec_t mk(string nm, logic [8:0] stb, logic [2:0] s1a, logic [2:0] s1b,
                              logic [2:0] s2, logic [7:0] adr, logic [7:0] cst, logic [2:0] obs,
                              logic [9:0] ins, logic z, logic [7:0] ma, logic [7:0] wd);
    vec_t v;
    v.name = nm; v.stb = stb; v.s1a = s1a; v.s1b = s1b; v.s2 = s2; v.adr = adr; v.cst = cst;
    v.obs = obs; v.e_ins = ins; v.e_z = z; v.e_ma = ma; v.e_wd = wd;
    return v;
  endfunction

  // Model: Bus_1 value from the select code rules
  function automatic logic [7:0] m_bus1(int sel, logic [7:0] cst);
    if (sel < 4)  return m_r[sel];
    if (sel == 4) return m_pc;
    if (sel == 5) return cst;
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_alu(int op, logic [7:0] a, logic [7:0] b);
    int r;
    case (op)
      0:       r = (int'(a) + int'(b)) % 256;
      1:       r = (int'(a) - int'(b) + 256) % 256;
      2:       r = int'(a & b);
      3:       r = int'(a | b);
      4:       r = 255 - int'(a);
      default: r = int'(a);
    endcase
    return r[7:0];
  endfunction

  // Model: advance one clock edge from the given inputs
  task automatic m_step(input logic [8:0] stb, input int s1a, input int s1b, input int s2,
                        input logic [7:0] adr, input logic [7:0] cst);
    logic [7:0] a, b, alu, b2;
    logic [9:0] rd;
    rd  = mem[m_ar];
    a   = m_bus1(s1a, cst);
    b   = m_bus1(s1b, cst);
    alu = m_alu(int'(m_ir[9:6]), a, b);
    case (s2)
      0: b2 = alu;
      1: b2 = a;
      2: b2 = rd[7:0];
      3: b2 = cst;
      4: b2 = adr;
      default: b2 = 8'h00;
    endcase
    for (int i = 0; i < 4; i++) if (stb[i]) m_r[i] = b2;
    if (stb[4])      m_pc = b2;
    else if (stb[5]) m_pc = m_pc + 8'd1;
    if (stb[6]) m_ir = rd;
    if (stb[7]) m_ar = b2;
    if (stb[8]) m_z  = (alu == 8'h00);
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_pc = 8'h00; m_ar = 8'h00; m_ir = 10'h000; m_z = 1'b0;
  endtask

  vec_t vt [$];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 10'h000;
    mem[8'h03] = 10'b0100001100;
    mem[8'h07] = 10'h0A5;
    mem[8'h20] = 10'h040;
    mem[8'h21] = 10'b0000000110;

    // Directed table; starts with R0=8'h11 left by the post-reset load
    vt.push_back(mk("ld_ar_21",   S_AR,        0,0,3, 8'h00,8'h21, 1, 10'h000,0,8'h21,8'h00));
    vt.push_back(mk("ld_ir_add",  S_IR,        0,0,0, 8'h00,8'h00, 1, 10'h006,0,8'h21,8'h00));
    vt.push_back(mk("ld_r0_05",   S_R0,        0,0,3, 8'h00,8'h05, 0, 10'h006,0,8'h21,8'h05));
    vt.push_back(mk("ld_r1_03",   S_R1,        0,0,3, 8'h00,8'h03, 1, 10'h006,0,8'h21,8'h03));
    vt.push_back(mk("add_r2",     S_R2|S_Z,    0,1,0, 8'h00,8'h00, 2, 10'h006,0,8'h21,8'h08));
    vt.push_back(mk("ld_r01_07",  S_R0|S_R1,   0,0,3, 8'h00,8'h07, 1, 10'h006,0,8'h21,8'h07));
    vt.push_back(mk("ld_ar_20",   S_AR,        0,0,3, 8'h00,8'h20, 0, 10'h006,0,8'h20,8'h07));
    vt.push_back(mk("ld_ir_sub",  S_IR,        0,0,0, 8'h00,8'h00, 0, 10'h040,0,8'h20,8'h07));
    vt.push_back(mk("sub_zero",   S_R3|S_Z,    0,1,0, 8'h00,8'h00, 3, 10'h040,1,8'h20,8'h00));
    vt.push_back(mk("ld_r0_00",   S_R0,        0,0,3, 8'h00,8'h00, 0, 10'h040,1,8'h20,8'h00));
    vt.push_back(mk("ld_r1_01",   S_R1,        0,0,3, 8'h00,8'h01, 1, 10'h040,1,8'h20,8'h01));
    vt.push_back(mk("sub_wrap",   S_R2|S_Z,    0,1,0, 8'h00,8'h00, 2, 10'h040,0,8'h20,8'hFF));
    vt.push_back(mk("self_load",  S_R2,        2,2,0, 8'h00,8'h00, 2, 10'h040,0,8'h20,8'h00));
    vt.push_back(mk("pc_ld_ff",   S_PC,        0,0,3, 8'h00,8'hFF, 4, 10'h040,0,8'h20,8'hFF));
    vt.push_back(mk("pc_wrap",    S_INC,       0,0,0, 8'h00,8'h00, 4, 10'h040,0,8'h20,8'h00));
    vt.push_back(mk("pc_ld_wins", S_PC|S_INC,  0,0,4, 8'h0F,8'h00, 4, 10'h040,0,8'h20,8'h0F));
    vt.push_back(mk("pc_hold",    9'h000,      0,0,0, 8'h00,8'h00, 4, 10'h040,0,8'h20,8'h0F));
    vt.push_back(mk("pc_ld_03",   S_PC,        0,0,3, 8'h00,8'h03, 4, 10'h040,0,8'h20,8'h03));
    vt.push_back(mk("fetch_ar",   S_AR|S_INC,  4,0,1, 8'h00,8'h00, 4, 10'h040,0,8'h03,8'h04));
    vt.push_back(mk("fetch_ir",   S_IR,        0,0,0, 8'h00,8'h00, 4, 10'h10C,0,8'h03,8'h04));
    vt.push_back(mk("ld_ar_07",   S_AR,        0,0,3, 8'h00,8'h07, 4, 10'h10C,0,8'h07,8'h04));
    vt.push_back(mk("mem_to_r3",  S_R3,        0,0,2, 8'h00,8'h00, 3, 10'h10C,0,8'h07,8'hA5));
    vt.push_back(mk("bus1_const", 9'h000,      0,0,0, 8'h00,8'h3C, 5, 10'h10C,0,8'h07,8'h3C));
    vt.push_back(mk("bus1_sel6",  9'h000,      0,0,0, 8'h00,8'h3C, 6, 10'h10C,0,8'h07,8'h00));
    vt.push_back(mk("ld_r0_ff",   S_R0,        0,0,3, 8'h00,8'hFF, 0, 10'h10C,0,8'h07,8'hFF));
    vt.push_back(mk("not_zero",   S_Z,         0,0,0, 8'h00,8'h00, 0, 10'h10C,1,8'h07,8'hFF));
    vt.push_back(mk("r1_addr",    S_R1,        0,0,4, 8'h5A,8'h00, 1, 10'h10C,1,8'h07,8'h5A));
    vt.push_back(mk("bus2_sel5",  S_R1,        0,0,5, 8'h66,8'h77, 1, 10'h10C,1,8'h07,8'h00));

    // Reset held with random strobes: state stays cleared
    drive(9'h000, 0, 0, 0, 8'h00, 8'h00);
    #2;
    chk("rst_ins0", bus.instruction, 10'h000);
    chk("rst_z0",   {9'h0, bus.zero}, 10'h000);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(9'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom));
      @(posedge clk); #1;
      drive(9'h000, 3'($urandom_range(0, 4)), 0, 0, 8'h00, 8'h00);
      #1;
      chk("rst_ins", bus.instruction, 10'h000);
      chk("rst_z",   {9'h0, bus.zero}, 10'h000);
      chk("rst_ma",  {2'b0, bus.mem_addr}, 10'h000);
      chk("rst_wd",  {2'b0, bus.mem_wdata}, 10'h000);
    end

    // Release: the first load lands on the next rising edge
    @(negedge clk);
    rst_n = 1'b1;
    drive(S_R0, 0, 0, 3, 8'h00, 8'h11);
    @(posedge clk); #1;
    drive(9'h000, 0, 0, 0, 8'h00, 8'h00);
    #1;
    chk("first_load", {2'b0, bus.mem_wdata}, 10'h011);

    // Directed vector table
    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].stb, vt[i].s1a, vt[i].s1b, vt[i].s2, vt[i].adr, vt[i].cst);
      @(posedge clk); #1;
      drive(9'h000, vt[i].obs, vt[i].s1b, vt[i].s2, vt[i].adr, vt[i].cst);
      #1;
      chk({vt[i].name, ".ins"}, bus.instruction, vt[i].e_ins);
      chk({vt[i].name, ".z"},   {9'h0, bus.zero}, {9'h0, vt[i].e_z});
      chk({vt[i].name, ".ma"},  {2'b0, bus.mem_addr}, {2'b0, vt[i].e_ma});
      chk({vt[i].name, ".wd"},  {2'b0, bus.mem_wdata}, {2'b0, vt[i].e_wd});
    end

    // Mid-cycle reset clears everything without waiting for an edge
    @(negedge clk);
    drive(9'h000, 3, 0, 0, 8'h00, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ins", bus.instruction, 10'h000);
    chk("mid_rst_z",   {9'h0, bus.zero}, 10'h000);
    chk("mid_rst_ma",  {2'b0, bus.mem_addr}, 10'h000);
    chk("mid_rst_wd",  {2'b0, bus.mem_wdata}, 10'h000);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();

    // Randomized traffic against the reference model
    for (int i = 0; i < 256; i++) mem[i] = 10'($urandom);
    for (int c = 0; c < 400; c++) begin
      logic [8:0] stb;
      int s1a, s1b, s2, obs;
      logic [7:0] adr, cst;
      @(negedge clk);
      for (int k = 0; k < 9; k++) stb[k] = ($urandom_range(0, 2) == 0);
      s1a = $urandom_range(0, 7); s1b = $urandom_range(0, 7); s2 = $urandom_range(0, 7);
      adr = 8'($urandom); cst = 8'($urandom);
      drive(stb, 3'(s1a), 3'(s1b), 3'(s2), adr, cst);
      m_step(stb, s1a, s1b, s2, adr, cst);
      @(posedge clk); #1;
      obs = $urandom_range(0, 7);
      drive(9'h000, 3'(obs), 3'(s1b), 3'(s2), adr, cst);
      #1;
      chk("rnd_ins", bus.instruction, m_ir);
      chk("rnd_z",   {9'h0, bus.zero}, {9'h0, m_z});
      chk("rnd_ma",  {2'b0, bus.mem_addr}, {2'b0, m_ar});
      chk("rnd_wd",  {2'b0, bus.mem_wdata}, {2'b0, m_bus1(obs, cst)});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
